ram_uart_dumper: RTL
====================

Name: ram_uart_dumper

Overview:
Downstream stage of the counter-and-store block.
- After the measurement run ends, it drains the 2048-entry count RAM through that block's read port.
- It drives read_enable one cycle per word; the upstream read address auto-increments from 0 on each such cycle.
- It captures each 32-bit word and transmits it as four 8N1 UART bytes on uart_tx toward the host.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
NUM_WORDS, 2048, words drained per dump.
RD_LATENCY, 1, clk cycles from the read_enable edge to valid read_data; legal range 1..3.
MSB_FIRST, 1, 1 = send read_data[31:24] first; 0 = send [7:0] first.

Ports:
clk  in  1  single clock; also drives the upstream RAM read clock (read_clk tied to clk).
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse (e.g. inst_end rising edge) that begins a dump; ignored while busy.
read_data  in  32  RAM read data from the upstream block.
read_enable  out  1  one-cycle RAM read strobe; upstream rd_addr increments on every asserted cycle.
uart_tx  out  1  serial output, idle high.
busy  out  1  high from the cycle after an accepted start until the last stop bit completes.
done  out  1  high after a full dump; cleared by the next accepted start or by reset.

Behaviour:
- Reset (async, rst=0):
  - Outputs: uart_tx=1, read_enable=0, busy=0, done=0.
  - Internal state: FSM goes to IDLE; word counter, byte index, bit counter and baud counter all go to 0.
  - Reset mid-frame truncates the frame immediately; uart_tx returns to 1.
- FSM states: IDLE, RD_REQ, RD_WAIT, LOAD, SEND, NEXT.
- IDLE:
  - start=1 moves to RD_REQ and clears done.
  - busy rises in the following cycle.
- RD_REQ: read_enable=1 for exactly one cycle, then go to RD_WAIT.
- RD_WAIT: wait RD_LATENCY cycles counted from the read_enable edge, then go to LOAD.
- LOAD:
  - Capture read_data into a 32-bit shift register.
  - Set byte index to 0 and go to SEND.
- SEND:
  - The tx sub-module sends the selected byte.
  - Byte select: MSB_FIRST=1 sends bytes [31:24], [23:16], [15:8], [7:0]; MSB_FIRST=0 sends the reverse order.
  - On tx_done, if byte index = 3 go to NEXT; otherwise increment the index and start the next byte.
  - Bytes are back-to-back: the next start bit begins the cycle after the previous stop bit ends.
- NEXT:
  - Increment the word counter.
  - If it equals NUM_WORDS: go to IDLE, set done=1, and drop busy in the same cycle.
  - Otherwise go to RD_REQ.
- UART frame:
  - One start bit (0), eight data bits LSB-first, one stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT cycles, giving 10*CLKS_PER_BIT cycles per byte.
- Totals:
  - Exactly NUM_WORDS read_enable pulses per dump; never two pulses in consecutive cycles.
  - Per-word period = 3 + RD_LATENCY + 40*CLKS_PER_BIT cycles.
- A start pulse while busy is dropped, not queued.
- The word counter is $clog2(NUM_WORDS+1) bits wide, so it must not wrap at NUM_WORDS=2048.
- The baud counter is 16 bits.
- This block issues no address. A second dump reads from whatever address the upstream rd_addr holds; the system resets both blocks together to restart at address 0.

Decomposition:
- Package ram_uart_pkg:
  - FSM state enum.
  - UART_FRAME_BITS=10.
  - BYTES_PER_WORD=4.
  - Default CLKS_PER_BIT constant.
- One sub-module, uart_tx_byte:
  - Parameter: CLKS_PER_BIT.
  - Ports: clk, rst, tx_start, tx_data[7:0], tx_line, tx_busy, tx_done.
  - tx_done is a one-cycle pulse on the final stop-bit cycle.
  - tx_start is accepted only when tx_busy=0.

Test Plan:
- Bench setup for all scenarios: CLKS_PER_BIT=4, NUM_WORDS=4, RD_LATENCY=1, with a behavioural RAM model holding words 0x11223344, 0xA5A5A5A5, 0x00000000, 0xFFFFFFFF at addresses 0..3.
- Reset then one start pulse -> uart_tx decodes as 16 bytes 11 22 33 44 A5 A5 A5 A5 00 00 00 00 FF FF FF FF; exactly 4 read_enable pulses; done=1; busy=0.
- Bit timing -> each bit holds exactly 4 cycles; each byte spans 40 cycles; stop-to-start gap between bytes is 0 cycles; read_enable pulses are 164 cycles apart.
- Start pulses repeated while busy -> no extra read_enable and output stream unchanged; start after done -> done clears and a new dump begins with read_enable 1 cycle later.
- MSB_FIRST=0 -> first word is sent as 44 33 22 11.
- RD_LATENCY=2 -> captured data is still correct; per-word period is 165 cycles.
- rst asserted mid-byte of word 2 -> uart_tx=1, busy=0, done=0 asynchronously; after release, no activity until the next start.

Source files
------------

// File: rtl/ram_uart_dumper_pkg.sv
// Shared types and constants for the RAM-to-UART dump path.
// The byte helpers keep the byte-order choice in one place.
package ram_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_LOAD,
    ST_SEND,
    ST_NEXT
  } state_e;

  localparam int UART_FRAME_BITS  = 10;
  localparam int BYTES_PER_WORD   = 4;
  localparam int DEF_CLKS_PER_BIT = 868;

  function automatic logic [7:0] head_byte(input logic [31:0] w, input bit msb_first);
    return msb_first ? w[31:24] : w[7:0];
  endfunction

  function automatic logic [31:0] shift_byte(input logic [31:0] w, input bit msb_first);
    return msb_first ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
  endfunction

endpackage

// File: rtl/ram_uart_dumper_if.sv
// Read port of the upstream count RAM; the dumper strobes, the RAM answers.
interface ram_uart_dumper_if #(parameter int DATA_W = 32);
  logic              read_enable;
  logic [DATA_W-1:0] read_data;

  modport master (output read_enable, input read_data);
  modport slave  (input read_enable, output read_data);
endinterface

// File: rtl/ram_uart_dumper_uart_tx_byte.sv
// 8N1 byte transmitter. tx_busy drops in the final stop-bit cycle so the
// next byte can start with no idle gap.
module uart_tx_byte
  import ram_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(UART_FRAME_BITS - 1);

  logic        active_q;
  logic [3:0]  bit_q;
  logic [15:0] baud_q;
  logic [7:0]  data_q;
  logic        line_q;
  logic        baud_end;

  assign baud_end = (baud_q == BAUD_LAST);
  assign tx_done  = active_q && baud_end && (bit_q == BIT_LAST);
  assign tx_busy  = active_q && !tx_done;
  assign tx_line  = line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      bit_q    <= '0;
      baud_q   <= '0;
      data_q   <= '0;
      line_q   <= 1'b1;
    end else if (tx_start && !tx_busy) begin
      active_q <= 1'b1;
      bit_q    <= '0;
      baud_q   <= '0;
      data_q   <= tx_data;
      line_q   <= 1'b0;
    end else if (active_q) begin
      if (!baud_end) begin
        baud_q <= baud_q + 16'd1;
      end else begin
        baud_q <= '0;
        if (bit_q == BIT_LAST) begin
          active_q <= 1'b0;
          bit_q    <= '0;
          line_q   <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
          // frame bit k+1 is data[k] for k=0..7, then the stop bit
          line_q <= (bit_q == BIT_LAST - 4'd1) ? 1'b1 : data_q[bit_q[2:0]];
        end
      end
    end
  end

endmodule

// File: rtl/ram_uart_dumper.sv
// Drains NUM_WORDS words from the upstream count RAM and streams each as
// four back-to-back 8N1 bytes on uart_tx.
module ram_uart_dumper
  import ram_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int NUM_WORDS    = 2048,
  parameter int RD_LATENCY   = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  ram_uart_dumper_if.master  ram,
  output logic               uart_tx,
  output logic               busy,
  output logic               done
);

  localparam int                CNT_W     = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NUM_WORDS);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam bit                MSB       = (MSB_FIRST != 0);

  state_e                 state_q;
  logic [CNT_W-1:0]       word_q, word_d;
  logic [1:0]             byte_q;
  logic [31:0]            shreg_q;
  logic                   re_q, busy_q, done_q;
  logic [RD_LATENCY-1:0]  vld_pipe_q;

  logic [31:0] tx_word;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy, tx_done;

  assign word_d = word_q + CNT_W'(1);

  // First byte comes straight off read_data so its start bit lands in the
  // first SEND cycle; later bytes come from the shifted capture.
  assign tx_word  = (state_q == ST_LOAD) ? ram.read_data : shift_byte(shreg_q, MSB);
  assign tx_data  = head_byte(tx_word, MSB);
  assign tx_start = !tx_busy && ((state_q == ST_LOAD) ||
                    ((state_q == ST_SEND) && tx_done && (byte_q != LAST_BYTE)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= re_q;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      re_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_RD_REQ;
          re_q    <= 1'b1;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          word_q  <= '0;
        end
        ST_RD_REQ:  state_q <= ST_RD_WAIT;
        ST_RD_WAIT: if (vld_pipe_q[RD_LATENCY-1]) state_q <= ST_LOAD;
        ST_LOAD: begin
          shreg_q <= ram.read_data;
          byte_q  <= '0;
          state_q <= ST_SEND;
        end
        ST_SEND: if (tx_done) begin
          if (byte_q == LAST_BYTE) begin
            state_q <= ST_NEXT;
          end else begin
            byte_q  <= byte_q + 2'd1;
            shreg_q <= shift_byte(shreg_q, MSB);
          end
        end
        ST_NEXT: begin
          word_q <= word_d;
          if (word_d == LAST_WORD) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RD_REQ;
            re_q    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram.read_enable = re_q;
  assign busy            = busy_q;
  assign done            = done_q;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_line  (uart_tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

endmodule
